// File: rtl/clk_rst_sequencer.sv
// Power sequencer for a bank of gated clock domains: qualifies PLL lock, brings domains up in order, tears them down in reverse.
// Optional macro AUTO_RESTART_EN: FAULT exits on its own as soon as synchronized lock returns.
module clk_rst_sequencer #(
    parameter int NUM_DOMAINS        = 4,
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int STEP_GAP_CYCLES    = 8
) (
    input  logic                   clk_in,
    input  logic                   reset_n,
    input  logic                   pll_locked,
    input  logic                   power_req,
    input  logic                   fault_clr,
    output logic [NUM_DOMAINS-1:0] clk_en_out,
    output logic [NUM_DOMAINS-1:0] dom_reset_n,
    output logic                   ready,
    output logic                   lock_lost,
    output logic [2:0]             state_o
);

    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int CNT_MAX = (LOCK_STABLE_CYCLES > STEP_GAP_CYCLES) ? LOCK_STABLE_CYCLES : STEP_GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        UP_CLK    = 3'd2,
        UP_RST    = 3'd3,
        RUN       = 3'd4,
        DN_RST    = 3'd5,
        DN_CLK    = 3'd6,
        FAULT     = 3'd7
    } state_t;

    state_t                 state, state_nx;
    logic [IDX_W-1:0]       idx, idx_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic [NUM_DOMAINS-1:0] clk_en_nx, dom_reset_n_nx;
    logic                   ready_nx, lock_lost_nx;
    logic [1:0]             lock_sync;
    logic                   lock_s, step_done, powered;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) lock_sync <= '0;
        else          lock_sync <= {lock_sync[0], pll_locked};
    end

    assign lock_s    = lock_sync[1];
    assign step_done = (cnt == STEP_LAST);
    assign powered   = state inside {UP_CLK, UP_RST, RUN, DN_RST, DN_CLK};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx       = state;
        idx_nx         = idx;
        cnt_nx         = cnt + 1'b1;
        clk_en_nx      = clk_en_out;
        dom_reset_n_nx = dom_reset_n;
        ready_nx       = ready;
        lock_lost_nx   = lock_lost & ~fault_clr;

        unique case (state)
            WAIT_LOCK: begin
                cnt_nx = '0;
                if (lock_s && power_req) state_nx = STABLE;
            end
            STABLE: begin
                if (!lock_s || !power_req) state_nx = WAIT_LOCK;
                else if (cnt == STABLE_LAST) begin
                    state_nx = UP_CLK;
                    idx_nx   = '0;
                end
            end
            UP_CLK: if (step_done) state_nx = power_req ? UP_RST : DN_RST;
            UP_RST: begin
                if (step_done) begin
                    if (!power_req)           state_nx = DN_RST;
                    else if (idx == IDX_LAST) state_nx = RUN;
                    else begin
                        idx_nx   = idx + 1'b1;
                        state_nx = UP_CLK;
                    end
                end
            end
            RUN: begin
                cnt_nx = '0;
                if (!power_req) begin
                    state_nx = DN_RST;
                    idx_nx   = IDX_LAST;
                end
            end
            DN_RST: if (step_done) state_nx = DN_CLK;
            DN_CLK: begin
                if (step_done) begin
                    if (idx == '0) state_nx = WAIT_LOCK;
                    else begin
                        idx_nx   = idx - 1'b1;
                        state_nx = DN_RST;
                    end
                end
            end
            FAULT: begin
                cnt_nx = '0;
`ifdef AUTO_RESTART_EN
                if (fault_clr || lock_s) state_nx = WAIT_LOCK;
`else
                if (fault_clr) state_nx = WAIT_LOCK;
`endif
            end
            default: state_nx = WAIT_LOCK;
        endcase

        // Lock loss outranks both power_req and step completion.
        if (powered && !lock_s) state_nx = FAULT;

        // Outputs are decided from the state being entered so they flip on the same edge as the state.
        if (state_nx != state) begin
            cnt_nx = '0;
            case (state_nx)
                UP_CLK: clk_en_nx[idx_nx] = 1'b1;
                UP_RST: dom_reset_n_nx[idx_nx] = 1'b1;
                RUN:    ready_nx = 1'b1;
                DN_RST: begin
                    dom_reset_n_nx[idx_nx] = 1'b0;
                    ready_nx               = 1'b0;
                end
                DN_CLK: clk_en_nx[idx_nx] = 1'b0;
                FAULT: begin
                    clk_en_nx      = '0;
                    dom_reset_n_nx = '0;
                    ready_nx       = 1'b0;
                    lock_lost_nx   = 1'b1;
                    idx_nx         = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!reset_n) begin
            state       <= WAIT_LOCK;
            idx         <= '0;
            cnt         <= '0;
            clk_en_out  <= '0;
            dom_reset_n <= '0;
            ready       <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            cnt         <= cnt_nx;
            clk_en_out  <= clk_en_nx;
            dom_reset_n <= dom_reset_n_nx;
            ready       <= ready_nx;
            lock_lost   <= lock_lost_nx;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Scoreboard bench for clk_rst_sequencer: a step-position reference model feeds an expectation queue,
// a negedge monitor pops and compares; directed edge-exact checks plus a randomized soak.
module tb_clk_rst_sequencer;

    localparam int N    = 4;
    localparam int LOCK = 16;
    localparam int GAP  = 8;

    logic         clk_in     = 1'b0;
    logic         reset_n    = 1'b0;
    logic         pll_locked = 1'b0;
    logic         power_req  = 1'b0;
    logic         fault_clr  = 1'b0;
    logic [N-1:0] clk_en_out, dom_reset_n;
    logic         ready, lock_lost;
    logic [2:0]   state_o;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    clk_rst_sequencer #(
        .NUM_DOMAINS       (N),
        .LOCK_STABLE_CYCLES(LOCK),
        .STEP_GAP_CYCLES   (GAP)
    ) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .power_req  (power_req),
        .fault_clr  (fault_clr),
        .clk_en_out (clk_en_out),
        .dom_reset_n(dom_reset_n),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .state_o    (state_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0]   st;
        logic [N-1:0] ce;
        logic [N-1:0] rn;
        logic         rdy;
        logic         lost;
    } exp_t;

    typedef enum int {M_IDLE, M_QUAL, M_UP, M_RUN, M_DOWN, M_FAULT} mode_t;

    exp_t  exp_q[$];
    mode_t m_mode   = M_IDLE;
    int    m_timer  = 0;
    int    m_pos    = 0;   // power-up step: even = clock of domain pos/2, odd = its reset release
    int    m_dom    = 0;
    bit    m_dn_clk = 1'b0;
    bit    m_lost   = 1'b0;
    bit    m_s1     = 1'b0;
    bit    m_s2     = 1'b0;
    bit    m_ls     = 1'b0;

    function automatic logic [N-1:0] first_n(input int n);
        return N'((1 << n) - 1);
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e      = '0;
        e.lost = m_lost;
        case (m_mode)
            M_QUAL: e.st = 3'd1;
            M_UP: begin
                e.st = (m_pos % 2 == 0) ? 3'd2 : 3'd3;
                e.ce = first_n(m_pos / 2 + 1);
                e.rn = first_n((m_pos + 1) / 2);
            end
            M_RUN: begin
                e.st  = 3'd4;
                e.ce  = '1;
                e.rn  = '1;
                e.rdy = 1'b1;
            end
            M_DOWN: begin
                e.st = m_dn_clk ? 3'd6 : 3'd5;
                e.ce = first_n(m_dn_clk ? m_dom : m_dom + 1);
                e.rn = first_n(m_dom);
            end
            M_FAULT: e.st = 3'd7;
            default: ;
        endcase
        return e;
    endfunction

    initial forever begin
        @(posedge clk_in or negedge reset_n);
        if (!reset_n) begin
            m_mode = M_IDLE; m_timer = 0; m_pos = 0; m_dom = 0;
            m_dn_clk = 1'b0; m_lost = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
            exp_q.delete();
            exp_q.push_back(model_out());
        end else begin
            m_ls = m_s2;
            m_s2 = m_s1;
            m_s1 = pll_locked;
            if (fault_clr) m_lost = 1'b0;
            if ((m_mode inside {M_UP, M_RUN, M_DOWN}) && !m_ls) begin
                m_mode = M_FAULT;
                m_lost = 1'b1;
            end else begin
                case (m_mode)
                    M_IDLE: if (m_ls && power_req) begin m_mode = M_QUAL; m_timer = 0; end
                    M_QUAL: begin
                        if (!m_ls || !power_req) m_mode = M_IDLE;
                        else if (m_timer == LOCK - 1) begin m_mode = M_UP; m_pos = 0; m_timer = 0; end
                        else m_timer++;
                    end
                    M_UP: begin
                        if (m_timer == GAP - 1) begin
                            m_timer = 0;
                            if (!power_req) begin m_mode = M_DOWN; m_dom = m_pos / 2; m_dn_clk = 1'b0; end
                            else if (m_pos == 2 * N - 1) m_mode = M_RUN;
                            else m_pos++;
                        end else m_timer++;
                    end
                    M_RUN: if (!power_req) begin m_mode = M_DOWN; m_dom = N - 1; m_dn_clk = 1'b0; m_timer = 0; end
                    M_DOWN: begin
                        if (m_timer == GAP - 1) begin
                            m_timer = 0;
                            if (!m_dn_clk) m_dn_clk = 1'b1;
                            else if (m_dom == 0) m_mode = M_IDLE;
                            else begin m_dom--; m_dn_clk = 1'b0; end
                        end else m_timer++;
                    end
                    M_FAULT: begin
`ifdef AUTO_RESTART_EN
                        if (fault_clr || m_ls) m_mode = M_IDLE;
`else
                        if (fault_clr) m_mode = M_IDLE;
`endif
                    end
                    default: ;
                endcase
            end
            exp_q.push_back(model_out());
        end
    end

    // ---------------- monitor ----------------
    exp_t mon_e;
    initial forever begin
        @(negedge clk_in);
        check("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("sb_state", state_o, mon_e.st);
            check("sb_clk_en", clk_en_out, mon_e.ce);
            check("sb_dom_reset_n", dom_reset_n, mon_e.rn);
            check("sb_ready", ready, mon_e.rdy);
            check("sb_lock_lost", lock_lost, mon_e.lost);
        end
        check("inv_rst_needs_clk", dom_reset_n & ~clk_en_out, 0);
        check("inv_clk_in_order", clk_en_out & (clk_en_out + 1'b1), 0);
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #2;
            edge_n++;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        while (state_o !== s && n < budget) begin
            tick(1);
            n++;
        end
        check(name, state_o, s);
    endtask

    int           wn;
    logic [N-1:0] seen;

    initial begin
        tick(3);
        check("reset_outputs", {clk_en_out, dom_reset_n, ready, lock_lost, state_o}, 0);

        // Power-up: lock rises at cycle 0
        reset_n = 1'b1; pll_locked = 1'b1; power_req = 1'b1; edge_n = 0;
        tick(18); check("pu_clk_en_e18", clk_en_out, 4'h0);
        tick(1);  check("pu_clk_en_e19", clk_en_out, 4'h1);
                  check("pu_state_e19", state_o, 3'd2);
        tick(7);  check("pu_rst_e26", dom_reset_n, 4'h0);
        tick(1);  check("pu_rst_e27", dom_reset_n, 4'h1);
        tick(8);  check("pu_clk_en_e35", clk_en_out, 4'h3);
        tick(47); check("pu_ready_e82", ready, 1'b0);
        tick(1);  check("pu_run_e83", {ready, clk_en_out, dom_reset_n, state_o}, {1'b1, 4'hF, 4'hF, 3'd4});

        // Shutdown from RUN
        tick(5); power_req = 1'b0;
        tick(1);  check("sd_first", {ready, clk_en_out, dom_reset_n, state_o}, {1'b0, 4'hF, 4'h7, 3'd5});
        tick(8);  check("sd_clk3_off", {clk_en_out, dom_reset_n, state_o}, {4'h7, 4'h7, 3'd6});
        tick(55); check("sd_e63", state_o, 3'd6);
        tick(1);  check("sd_idle", {clk_en_out, dom_reset_n, ready, lock_lost, state_o}, 0);

        // Lock glitch during qualification
        power_req = 1'b1;
        tick(1);  check("gl_stable", state_o, 3'd1);
        tick(10); pll_locked = 1'b0;
        tick(3);  check("gl_back_to_wait", {lock_lost, state_o}, 0);
        pll_locked = 1'b1;
        tick(18); check("gl_requal_e31", {clk_en_out, state_o}, {4'h0, 3'd1});
        tick(1);  check("gl_requal_e32", {clk_en_out, state_o}, {4'h1, 3'd2});
        wait_state(3'd4, 200, "gl_reaches_run");

        // Lock loss in RUN
        tick(3); pll_locked = 1'b0;
        tick(2); check("ll_before", state_o, 3'd4);
        tick(1); check("ll_fault", {clk_en_out, dom_reset_n, ready, lock_lost, state_o},
                       {4'h0, 4'h0, 1'b0, 1'b1, 3'd7});
        pll_locked = 1'b1;
`ifdef AUTO_RESTART_EN
        wait_state(3'd4, 200, "ll_auto_run");
        check("ll_auto_sticky", lock_lost, 1'b1);
        fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
        check("ll_auto_clr", lock_lost, 1'b0);
`else
        tick(12); check("ll_fault_held", {lock_lost, state_o}, {1'b1, 3'd7});
        fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
        check("ll_cleared", {lock_lost, state_o}, {1'b0, 3'd0});
`endif
        power_req = 1'b0;
        wait_state(3'd0, 100, "idle_before_abort");

        // Abort mid power-up at UP_RST(1)
        power_req = 1'b1;
        wn = 0;
        while (!(state_o == 3'd3 && clk_en_out == 4'h3) && wn < 300) begin tick(1); wn++; end
        check("ab_at_up_rst1", {state_o, clk_en_out}, {3'd3, 4'h3});
        power_req = 1'b0; seen = '0; wn = 0;
        while (state_o != 3'd0 && wn < 300) begin
            tick(1);
            seen |= clk_en_out | dom_reset_n;
            wn++;
        end
        check("ab_idle", state_o, 3'd0);
        check("ab_upper_untouched", seen[3:2], 0);
        check("ab_outputs_off", {clk_en_out, dom_reset_n, ready}, 0);

        // Asynchronous reset pulse in RUN
        power_req = 1'b1;
        wait_state(3'd4, 300, "ar_run");
        reset_n = 1'b0;
        #1;
        check("ar_immediate", {clk_en_out, dom_reset_n, ready, lock_lost, state_o}, 0);
        tick(2); reset_n = 1'b1;

        // Randomized soak against the model
        for (int i = 0; i < 4000; i++) begin
            if (pll_locked) begin
                if ($urandom_range(0, 199) == 0) pll_locked = 1'b0;
            end else if ($urandom_range(0, 9) == 0) pll_locked = 1'b1;
            if (power_req) begin
                if ($urandom_range(0, 149) == 0) power_req = 1'b0;
            end else if ($urandom_range(0, 29) == 0) power_req = 1'b1;
            fault_clr = ($urandom_range(0, 49) == 0);
            tick(1);
        end
        fault_clr = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
